// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST launcher: FSM state encoding,
// default timing constants and the timeout-counter width helper.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    REPORT
  } state_t;

  localparam int unsigned START_CYCLES_DEF   = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  // Bits needed to count up to 'cycles' inclusive.
  function automatic int unsigned timeout_ctr_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/bist_timeout_ctr.sv
// Loadable, clearable up-counter with a registered terminal-count flag.
// 'expired' is high in the cycle whose count equals 'limit'.
module bist_timeout_ctr #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W-1:0] count_n;

  // Next count: clear wins over load, load wins over increment.
  always_comb begin
    count_n = count;
    if (clear) begin
      count_n = '0;
    end else if (load) begin
      count_n = load_value;
    end else if (inc) begin
      count_n = count + W'(1);
    end
  end

  // Count register and terminal flag registered against the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_n;
      expired <= (count_n == limit);
    end
  end

endmodule

// File: rtl/bist_launcher.sv
// Host-side BIST campaign initiator: launches N back-to-back runs over the
// start/done/fail handshake, guards each run with a timeout and reports one
// aggregate verdict. Optional macro BIST_LAUNCH_STOP_ON_FAIL_EN ends the
// campaign at the first failing run.
module bist_launcher
  import bist_pkg::*;
#(
  parameter int unsigned START_CYCLES   = START_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [CNT_W-1:0] num_runs,
  output logic             start,
  input  logic             done,
  input  logic             fail,
  output logic             busy,
  output logic             result_valid,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
  output logic             timeout
);

  localparam int unsigned CTR_W =
    timeout_ctr_width((START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES);
  localparam logic [CTR_W-1:0] START_LIMIT   = CTR_W'(START_CYCLES - 1);
  localparam logic [CTR_W-1:0] TIMEOUT_LIMIT = CTR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  state_t           state, state_n;
  logic [CNT_W-1:0] runs_left, runs_left_n;
  logic             armed, armed_n;
  logic [CNT_W-1:0] fail_count_n;
  logic             timeout_n;
  logic             pass_n;
  logic             ctr_clear;
  logic             ctr_inc;
  logic [CTR_W-1:0] ctr_limit;
  logic             ctr_expired;

  // One counter serves both the START pulse width and the WAIT timeout;
  // it restarts on every state change.
  assign ctr_clear = (state_n != state);
  assign ctr_inc   = (state == START) || (state == WAIT);
  assign ctr_limit = (state_n == START) ? START_LIMIT : TIMEOUT_LIMIT;

  bist_timeout_ctr #(
    .W (CTR_W)
  ) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .clear      (ctr_clear),
    .load       (1'b0),
    .load_value ('0),
    .inc        (ctr_inc),
    .limit      (ctr_limit),
    .expired    (ctr_expired)
  );

  // Next-state and campaign bookkeeping.
  always_comb begin
    state_n      = state;
    runs_left_n  = runs_left;
    armed_n      = armed;
    fail_count_n = fail_count;
    timeout_n    = timeout;
    pass_n       = pass;
    case (state)
      IDLE: begin
        if (go) begin
          state_n      = START;
          runs_left_n  = (num_runs == '0) ? CNT_W'(1) : num_runs;
          armed_n      = 1'b0;
          fail_count_n = '0;
          timeout_n    = 1'b0;
          pass_n       = 1'b0;
        end
      end
      START: begin
        if (!done) armed_n = 1'b1;
        if (ctr_expired) state_n = WAIT;
      end
      WAIT: begin
        // A done level only counts once it has been seen low during this run.
        if (armed && done) begin
          if (fail && (fail_count != CNT_MAX)) fail_count_n = fail_count + CNT_W'(1);
          runs_left_n = runs_left - CNT_W'(1);
          armed_n     = 1'b0;
          if (runs_left == CNT_W'(1)) begin
            state_n = REPORT;
`ifdef BIST_LAUNCH_STOP_ON_FAIL_EN
          end else if (fail) begin
            state_n = REPORT;
`endif
          end else begin
            state_n = START;
          end
        end else begin
          if (!done) armed_n = 1'b1;
          if (ctr_expired) begin
            timeout_n = 1'b1;
            if (fail_count != CNT_MAX) fail_count_n = fail_count + CNT_W'(1);
            state_n = REPORT;
          end
        end
      end
      REPORT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state_n == REPORT) pass_n = (fail_count_n == '0) && !timeout_n;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Campaign registers and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      runs_left    <= '0;
      armed        <= 1'b0;
      fail_count   <= '0;
      timeout      <= 1'b0;
      pass         <= 1'b0;
      start        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      runs_left    <= runs_left_n;
      armed        <= armed_n;
      fail_count   <= fail_count_n;
      timeout      <= timeout_n;
      pass         <= pass_n;
      start        <= (state_n == START);
      busy         <= (state_n != IDLE);
      result_valid <= (state_n == REPORT);
    end
  end

endmodule

// File: tb/tb_bist_launcher.sv
// Self-checking bench for bist_launcher: a behavioural BIST engine answers
// start pulses, a campaign-level model predicts the verdict.
module tb_bist_launcher;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SCYC  = 2;
  localparam int unsigned TMO   = 1024;
`ifdef BIST_LAUNCH_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0;
  logic [CNT_W-1:0] num_runs = '0;
  logic             start;
  logic             done = 1'b0;
  logic             fail = 1'b0;
  logic             busy;
  logic             result_valid;
  logic             pass;
  logic [CNT_W-1:0] fail_count;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  bist_launcher #(
    .START_CYCLES   (SCYC),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .num_runs     (num_runs),
    .start        (start),
    .done         (done),
    .fail         (fail),
    .busy         (busy),
    .result_valid (result_valid),
    .pass         (pass),
    .fail_count   (fail_count),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Engine configuration (written by the main sequence only).
  bit fail_bits [0:511];
  int eng_lat   = 4;
  bit eng_stuck = 1'b0;
  int run_base  = 0;

  // Behavioural BIST engine: drops done on a start rise, raises it with the
  // run's fail bit eng_lat cycles later; fail is noise while done is low.
  int   eng_idx = 0;
  int   eng_cnt = 0;
  int   eng_run = 0;
  bit   eng_busy = 1'b0;
  logic eng_start_d = 1'b0;
  always @(negedge clk) begin
    if (!eng_stuck) begin
      if (start && !eng_start_d) begin
        done     = 1'b0;
        eng_cnt  = eng_lat;
        eng_run  = eng_idx - run_base;
        eng_idx++;
        eng_busy = 1'b1;
      end else if (eng_busy) begin
        if (eng_cnt <= 1) begin
          done     = 1'b1;
          fail     = fail_bits[eng_run];
          eng_busy = 1'b0;
        end else begin
          eng_cnt--;
        end
      end
      if (!done) fail = 1'($urandom_range(0, 1));
    end
    eng_start_d = start;
  end

  // Monitor: start pulses, pulse widths, consecutive WAIT cycles.
  int   mon_starts = 0;
  int   mon_bad_w  = 0;
  int   mon_wait   = 0;
  int   mon_w      = 0;
  logic mon_prev   = 1'b0;
  always @(negedge clk) begin
    if (start) begin
      if (!mon_prev) begin
        mon_starts++;
        mon_w = 0;
      end
      mon_w++;
      mon_wait = 0;
    end else if (mon_prev && !rst && mon_w != SCYC) begin
      mon_bad_w++;
    end
    if (busy && !start && !result_valid) mon_wait++;
    mon_prev = start;
  end

  task automatic set_fails(input int pct);
    for (int i = 0; i < 512; i++) fail_bits[i] = ($urandom_range(0, 99) < pct);
  endtask

  // Run one campaign and compare against the campaign-level model.
  task automatic campaign(input string tag, input int n, input int lat,
                          input bit stuck, input bit spam);
    int runs, exp_starts, exp_fc, s0, b0, budget;
    bit exp_to, exp_pass, seen;
    runs       = (n == 0) ? 1 : n;
    exp_starts = 0;
    exp_fc     = 0;
    exp_to     = 1'b0;
    if (stuck) begin
      exp_starts = 1;
      exp_fc     = 1;
      exp_to     = 1'b1;
    end else begin
      for (int i = 0; i < runs; i++) begin
        exp_starts++;
        if (fail_bits[i]) begin
          exp_fc = (exp_fc < 255) ? exp_fc + 1 : 255;
          if (STOP_ON_FAIL) break;
        end
      end
    end
    exp_pass = (exp_fc == 0) && !exp_to;

    eng_lat   = lat;
    eng_stuck = stuck;
    tick();
    s0       = mon_starts;
    b0       = mon_bad_w;
    run_base = eng_idx;
    go       = 1'b1;
    num_runs = CNT_W'(n);
    tick();
    go = 1'b0;
    check({tag, "_start_rise"}, start, 1);
    check({tag, "_busy_rise"}, busy, 1);

    budget = 200 + runs * (lat + SCYC + 4) + TMO;
    seen   = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      go       = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      num_runs = CNT_W'($urandom);
      tick();
    end
    go = 1'b0;
    check({tag, "_result_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_fail_count"}, fail_count, exp_fc);
      check({tag, "_pass"}, pass, exp_pass);
      check({tag, "_timeout"}, timeout, exp_to);
      check({tag, "_busy_in_report"}, busy, 1);
      check({tag, "_start_pulses"}, mon_starts - s0, exp_starts);
      check({tag, "_bad_widths"}, mon_bad_w - b0, 0);
      if (stuck) check({tag, "_wait_cycles"}, mon_wait, TMO);
      tick();
      check({tag, "_rv_one_cycle"}, result_valid, 0);
      check({tag, "_busy_fall"}, busy, 0);
      check({tag, "_pass_held"}, pass, exp_pass);
      tick();
      tick();
      check({tag, "_stays_idle"}, start | busy, 0);
    end
  endtask

  initial begin
    set_fails(0);
    tick();
    check("reset_start", start, 0);
    check("reset_busy", busy, 0);
    check("reset_rv", result_valid, 0);
    check("reset_pass", pass, 0);
    check("reset_timeout", timeout, 0);
    check("reset_fail_count", fail_count, 0);
    rst = 1'b0;
    tick();

    campaign("one_run", 1, 300, 1'b0, 1'b0);

    set_fails(0);
    fail_bits[1] = 1'b1;
    campaign("three_runs", 3, $urandom_range(2, 20), 1'b0, 1'b0);

    set_fails(0);
    campaign("stuck_done", 2, 5, 1'b1, 1'b0);

    set_fails(0);
    campaign("zero_runs", 0, 5, 1'b0, 1'b0);

    set_fails(100);
    campaign("all_fail_255", 255, 2, 1'b0, 1'b1);

    set_fails(0);
    campaign("pass_before_rst", 2, 3, 1'b0, 1'b0);

    // Reset while start is high: start drops before the next clock edge.
    tick();
    go       = 1'b1;
    num_runs = CNT_W'(3);
    tick();
    go = 1'b0;
    check("rst_pre_start", start, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_fail_count", fail_count, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_idle_after", start | busy | result_valid, 0);
    set_fails(30);
    campaign("after_rst", 3, $urandom_range(1, 15), 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      set_fails($urandom_range(0, 50));
      campaign("random", $urandom_range(0, 6), $urandom_range(1, 20), 1'b0,
               1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
